// File: rtl/offchip_pkg.sv
// rtl/offchip_pkg.sv - shared widths, beat math and FSM state type for the off-chip TX serializer
package offchip_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int LINK_W_DEF = 16;
    localparam int BEATS_DEF  = DATA_W_DEF / LINK_W_DEF;

    // A beat index needs at least one bit even when a word is a single beat.
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEAT_IDX_W = beat_idx_w(BEATS_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/offchip_word_fifo.sv
// rtl/offchip_word_fifo.sv - synchronous word FIFO with occupancy count and full/empty flags
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push/i_data write one word (ignored when full)
//   i_pop         drop the head word (ignored when empty)
//   o_data        head word, valid while !o_empty
//   o_count       number of stored words
//   o_full        o_count == DEPTH
//   o_empty       o_count == 0
module offchip_word_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/offchip_tx_serializer.sv
// rtl/offchip_tx_serializer.sv - buffers 64-bit words and serializes them LSB-first onto a narrow off-chip link
//
// Optional feature macro: OFFCHIP_PARITY_EN (adds link_parity, even parity of link_data).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   valid_in     upstream word valid
//   data_in      upstream word
//   ready_out    upstream may transfer (FIFO not full, low in reset)
//   link_valid   beat valid on the link
//   link_data    current beat (low LINK_W bits of the shift register)
//   link_last    final beat of the current word
//   link_ready   link sink accepts the beat
//   words_sent   count of completely transmitted words, wraps
//   link_parity  (OFFCHIP_PARITY_EN only) ^link_data
module offchip_tx_serializer
    import offchip_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LINK_W     = LINK_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ready_out,
    output logic                link_valid,
    output logic [LINK_W-1:0]   link_data,
    output logic                link_last,
    input  logic                link_ready,
    output logic [CNT_W-1:0]    words_sent
`ifdef OFFCHIP_PARITY_EN
    ,
    output logic                link_parity
`endif
);

    localparam int BEATS = DATA_W / LINK_W;
    localparam int IDX_W = beat_idx_w(BEATS);

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [DATA_W-1:0]      r_shift;
    logic [IDX_W-1:0]       r_beat_idx;
    logic [CNT_W-1:0]       r_words_sent;

    logic                   w_push;
    logic                   w_pop;
    logic [DATA_W-1:0]      w_fifo_data;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_sending;
    logic                   w_last_beat;
    logic                   w_beat_xfer;

    offchip_word_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Depends only on stored occupancy, never on this cycle's pop, so a full
    // FIFO keeps upstream stalled for a cycle even while a word leaves.
    assign ready_out   = !rst && !w_full;
    assign w_push      = valid_in && ready_out;

    assign w_sending   = (r_state == SEND);
    assign w_last_beat = (r_beat_idx == IDX_W'(BEATS - 1));
    assign w_beat_xfer = w_sending && link_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A word's last beat and the next word's load share one edge, so
    // back-to-back words leave no idle cycle on the link.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (link_ready && w_last_beat) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_beat_idx <= '0;
        end else if (w_pop) begin
            r_shift    <= w_fifo_data;
            r_beat_idx <= '0;
        end else if (w_beat_xfer && !w_last_beat) begin
            r_shift    <= r_shift >> LINK_W;
            r_beat_idx <= r_beat_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_sent <= '0;
        end else if (w_beat_xfer && w_last_beat) begin
            r_words_sent <= r_words_sent + 1'b1;
        end
    end

    assign link_valid = w_sending;
    assign link_data  = w_sending ? r_shift[LINK_W-1:0] : '0;
    assign link_last  = w_sending && w_last_beat;
    assign words_sent = r_words_sent;

`ifdef OFFCHIP_PARITY_EN
    assign link_parity = ^link_data;
`endif

endmodule
